// File: rtl/q_dequant.sv
// q_dequant: three-stage int8 -> Q(FRAC_BITS) dequantizer.
// Subtract zero point, multiply by a Q31 scale, then round half-up, shift and saturate.
`default_nettype none

module q_dequant #(
    parameter int FRAC_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic signed [31:0] cfg_zero_point,
    input  logic signed [31:0] cfg_multiplier,
    input  logic        [5:0]  cfg_rshift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_data,
    output logic               idle,
    output logic               sat_flag
);

    // FRAC_BITS only documents the output format; it must fit the 32-bit result.
    if (FRAC_BITS > 31) begin : g_frac_bits_range
    end

    localparam logic signed [64:0] C_MAX = 65'sd2147483647;
    localparam logic signed [64:0] C_MIN = -65'sd2147483648;

    logic signed [31:0] zp_q, zp_d;
    logic signed [31:0] mult_q, mult_d;
    logic        [5:0]  rshift_q, rshift_d;

    logic               s1_v_q, s1_v_d;
    logic signed [32:0] s1_diff_q, s1_diff_d;
    logic               s2_v_q, s2_v_d;
    logic signed [64:0] s2_prod_q, s2_prod_d;
    logic               out_valid_q, out_valid_d;
    logic signed [31:0] out_data_q, out_data_d;
    logic               sat_q, sat_d;

    logic               en;
    logic               accept;
    logic               cfg_accept;
    logic signed [32:0] w_diff;
    logic signed [64:0] w_prod;
    logic signed [64:0] w_rnd;
    logic signed [64:0] w_sum;
    logic signed [64:0] w_shr;
    logic signed [31:0] w_clip;
    logic               w_sat;

    assign en         = out_ready | ~out_valid_q;
    assign idle       = ~(s1_v_q | s2_v_q | out_valid_q);
    assign in_ready   = en & ~cfg_load;
    assign accept     = in_valid & in_ready;
    assign cfg_accept = cfg_load & idle;

    assign w_diff = $signed({{25{in_data[7]}}, in_data}) - $signed({zp_q[31], zp_q});
    assign w_prod = $signed({{32{s1_diff_q[32]}}, s1_diff_q})
                  * $signed({{33{mult_q[31]}}, mult_q});

    // The product magnitude stays below 2^63, so the 65-bit rounding add cannot wrap.
    assign w_rnd = (rshift_q == 6'd0) ? 65'sd0 : (65'sd1 <<< (rshift_q - 6'd1));
    assign w_sum = s2_prod_q + w_rnd;
    assign w_shr = w_sum >>> rshift_q;

    always_comb begin
        w_sat  = 1'b0;
        w_clip = w_shr[31:0];
        if (w_shr > C_MAX) begin
            w_clip = 32'h7FFF_FFFF;
            w_sat  = 1'b1;
        end else if (w_shr < C_MIN) begin
            w_clip = 32'h8000_0000;
            w_sat  = 1'b1;
        end
    end

    always_comb begin
        zp_d        = zp_q;
        mult_d      = mult_q;
        rshift_d    = rshift_q;
        s1_v_d      = s1_v_q;
        s1_diff_d   = s1_diff_q;
        s2_v_d      = s2_v_q;
        s2_prod_d   = s2_prod_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;

        if (en) begin
            s1_v_d      = accept;
            s1_diff_d   = w_diff;
            s2_v_d      = s1_v_q;
            s2_prod_d   = w_prod;
            out_valid_d = s2_v_q;
            out_data_d  = w_clip;
            if (s2_v_q && w_sat) begin
                sat_d = 1'b1;
            end
        end

        // Only reachable with an empty pipeline, so no beat ever sees a config change.
        if (cfg_accept) begin
            zp_d     = cfg_zero_point;
            mult_d   = cfg_multiplier;
            rshift_d = cfg_rshift;
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zp_q        <= '0;
            mult_q      <= '0;
            rshift_q    <= '0;
            s1_v_q      <= 1'b0;
            s1_diff_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            zp_q        <= zp_d;
            mult_q      <= mult_d;
            rshift_q    <= rshift_d;
            s1_v_q      <= s1_v_d;
            s1_diff_q   <= s1_diff_d;
            s2_v_q      <= s2_v_d;
            s2_prod_q   <= s2_prod_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule

`default_nettype wire
